// File: rtl/lowampa_matched_filter_prog_if.sv
// rtl/lowampa_matched_filter_prog_if.sv - sample, coefficient-load and result bundle for the programmable matched filter
interface lowampa_matched_filter_prog_if #(
    parameter int NBITS     = 12,
    parameter int NSAMPS    = 4,
    parameter int NTAPS     = 80,
    parameter int COEF_BITS = 4,
    parameter int OW        = 12
);
    logic [NBITS*NSAMPS-1:0]   in_i;
    logic                      in_valid_i;
    logic                      coef_wr_i;
    logic [$clog2(NTAPS)-1:0]  coef_addr_i;
    logic [COEF_BITS-1:0]      coef_dat_i;
    logic                      coef_commit_i;
    logic                      coef_busy_o;
    logic [OW*NSAMPS-1:0]      out_o;
    logic                      out_valid_o;
    logic [NSAMPS-1:0]         sat_o;

    modport master (
        output in_i, in_valid_i, coef_wr_i, coef_addr_i, coef_dat_i, coef_commit_i,
        input  coef_busy_o, out_o, out_valid_o, sat_o
    );

    modport slave (
        input  in_i, in_valid_i, coef_wr_i, coef_addr_i, coef_dat_i, coef_commit_i,
        output coef_busy_o, out_o, out_valid_o, sat_o
    );
endinterface

// File: rtl/lowampa_matched_filter_prog.sv
// rtl/lowampa_matched_filter_prog.sv - programmable NSAMPS-parallel FIR with shadow/active taps, scaling and saturation
// Optional rounding (round-half-up before the shift) is enabled by defining LOWAMPA_MF_ROUND_EN.
module lowampa_matched_filter_prog #(
    parameter int NBITS     = 12,
    parameter int NSAMPS    = 4,
    parameter int NTAPS     = 80,
    parameter int COEF_BITS = 4,
    parameter int OUT_SHIFT = 4,
    parameter int OUTQ_INT  = 12,
    parameter int OUTQ_FRAC = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    lowampa_matched_filter_prog_if.slave  bus
);
    localparam int OW         = OUTQ_INT + OUTQ_FRAC;
    localparam int L          = $clog2(NTAPS);
    localparam int P          = 1 << L;
    localparam int W          = NBITS + COEF_BITS + L;
    localparam int FILL_WORDS = (NTAPS - 1 + NSAMPS - 1) / NSAMPS;
    localparam int CW         = $clog2(FILL_WORDS + 1);
    localparam logic signed [W:0] MAXV = (W+1)'((1 <<< (OW - 1)) - 1);
    localparam logic signed [W:0] MINV = (W+1)'(-(1 <<< (OW - 1)));
`ifdef LOWAMPA_MF_ROUND_EN
    localparam logic signed [W:0] RND  = (W+1)'((1 <<< OUT_SHIFT) >>> 1);
`endif

    typedef enum logic {S_FILL, S_RUN} state_t;

    logic signed [COEF_BITS-1:0] shadow_q   [NTAPS];
    logic signed [COEF_BITS-1:0] shadow_nxt [NTAPS];
    logic signed [COEF_BITS-1:0] active_q   [NTAPS];
    logic signed [NBITS-1:0]     hist_q     [NTAPS-1];
    logic signed [NBITS-1:0]     win        [NTAPS+NSAMPS-1];
    logic signed [W-1:0]         prod       [NSAMPS][P];
    // Heap-ordered adder tree: leaves at P..2P-1, node i sums 2i and 2i+1, root at 1.
    logic signed [W-1:0]         node_q     [NSAMPS][1:2*P-1];
    logic [L:0]                  tag_q;
    logic                        tag_in;
    state_t                      state_q;
    logic [CW-1:0]               cnt_q;
    logic signed [W:0]           ext, shf;
    logic [OW*NSAMPS-1:0]        out_nxt;
    logic [NSAMPS-1:0]           sat_nxt;

    always_comb begin
        shadow_nxt = shadow_q;
        if (bus.coef_wr_i && int'(bus.coef_addr_i) < NTAPS)
            shadow_nxt[bus.coef_addr_i] = bus.coef_dat_i;
    end

    // win[0] is the newest sample; age increases with index.
    always_comb begin
        for (int j = 0; j < NSAMPS; j++)
            win[j] = bus.in_i[NBITS*(NSAMPS-1-j) +: NBITS];
        for (int m = 0; m < NTAPS-1; m++)
            win[NSAMPS+m] = hist_q[m];
    end

    always_comb begin
        for (int k = 0; k < NSAMPS; k++) begin
            for (int t = 0; t < NTAPS; t++)
                prod[k][t] = W'(win[NSAMPS-1-k+t] * active_q[t]);
            for (int t = NTAPS; t < P; t++)
                prod[k][t] = '0;
        end
    end

    assign tag_in = bus.in_valid_i && (state_q == S_RUN);

    always_comb begin
        out_nxt = '0;
        sat_nxt = '0;
        ext     = '0;
        shf     = '0;
        for (int k = 0; k < NSAMPS; k++) begin
            ext = {node_q[k][1][W-1], node_q[k][1]};
`ifdef LOWAMPA_MF_ROUND_EN
            ext = ext + RND;
`endif
            shf = ext >>> OUT_SHIFT;
            if (shf > MAXV) begin
                out_nxt[k*OW +: OW] = MAXV[OW-1:0];
                sat_nxt[k]          = 1'b1;
            end else if (shf < MINV) begin
                out_nxt[k*OW +: OW] = MINV[OW-1:0];
                sat_nxt[k]          = 1'b1;
            end else begin
                out_nxt[k*OW +: OW] = shf[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NTAPS; t++) begin
                shadow_q[t] <= '0;
                active_q[t] <= '0;
            end
            for (int m = 0; m < NTAPS-1; m++)
                hist_q[m] <= '0;
            for (int k = 0; k < NSAMPS; k++)
                for (int i = 1; i < 2*P; i++)
                    node_q[k][i] <= '0;
            tag_q           <= '0;
            state_q         <= S_FILL;
            cnt_q           <= CW'(FILL_WORDS);
            bus.coef_busy_o <= 1'b1;
            bus.out_o       <= '0;
            bus.out_valid_o <= 1'b0;
            bus.sat_o       <= '0;
        end else begin
            shadow_q <= shadow_nxt;
            if (bus.coef_commit_i)
                active_q <= shadow_nxt;
            if (bus.in_valid_i)
                for (int m = 0; m < NTAPS-1; m++)
                    hist_q[m] <= win[m];
            for (int k = 0; k < NSAMPS; k++) begin
                for (int t = 0; t < P; t++)
                    node_q[k][P+t] <= prod[k][t];
                for (int i = 1; i < P; i++)
                    node_q[k][i] <= node_q[k][2*i] + node_q[k][2*i+1];
            end

            // A commit kills everything in flight so no output mixes two banks.
            if (bus.coef_commit_i) begin
                tag_q           <= '0;
                bus.out_valid_o <= 1'b0;
                state_q         <= S_FILL;
                cnt_q           <= CW'(FILL_WORDS);
                bus.coef_busy_o <= 1'b1;
            end else begin
                tag_q           <= {tag_q[L-1:0], tag_in};
                bus.out_valid_o <= tag_q[L];
                if (tag_q[L]) begin
                    bus.out_o <= out_nxt;
                    bus.sat_o <= sat_nxt;
                end
                if (state_q == S_FILL && bus.in_valid_i) begin
                    if (cnt_q == CW'(1)) begin
                        state_q         <= S_RUN;
                        cnt_q           <= '0;
                        bus.coef_busy_o <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
            end
        end
    end
endmodule
